// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - FSM state type and rotate-priority pick for the packet arbiter
package axis_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   localparam int MAX_PORTS = 16;

   // First set bit of req searched from last+1 upward, wrapping at num-1 -> 0.
   function automatic logic [3:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                          input logic [3:0]           last,
                                          input logic [4:0]           num);
      logic [3:0] pick;
      logic       found;
      logic [4:0] idx;
      pick  = 4'd0;
      found = 1'b0;
      for (int k = 1; k <= MAX_PORTS; k++) begin
         idx = 5'({1'b0, last}) + 5'(k);
         if (idx >= num) idx = idx - num;
         if (!found && (5'(k) <= num) && req[idx[3:0]]) begin
            pick  = idx[3:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - two-entry skid buffer with registered valid and ready
module axis_reg_slice #(
   parameter int DSIZE = 16,
   parameter int USIZE = 1
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             s_tvalid_i,
   output logic             s_tready_o,
   input  logic [DSIZE-1:0] s_tdata_i,
   input  logic             s_tlast_i,
   input  logic [USIZE-1:0] s_tuser_i,
   output logic             m_tvalid_o,
   input  logic             m_tready_i,
   output logic [DSIZE-1:0] m_tdata_o,
   output logic             m_tlast_o,
   output logic [USIZE-1:0] m_tuser_o
);

   localparam int W = DSIZE + USIZE + 1;

   logic [W-1:0] main_q, main_d, skid_q, skid_d, in_beat;
   logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic         s_hs;

   assign in_beat    = {s_tuser_i, s_tlast_i, s_tdata_i};
   assign s_tready_o = ~skid_vld_q;
   assign s_hs       = s_tvalid_i & ~skid_vld_q;

   // The skid entry only fills when the output is stalled, so ready drops one cycle late safely.
   always_comb begin
      main_vld_d = main_vld_q;
      main_d     = main_q;
      skid_vld_d = skid_vld_q;
      skid_d     = skid_q;
      if (!main_vld_q || m_tready_i) begin
         if (skid_vld_q) begin
            main_vld_d = 1'b1;
            main_d     = skid_q;
            skid_vld_d = 1'b0;
         end else begin
            main_vld_d = s_hs;
            if (s_hs) main_d = in_beat;
         end
      end else if (s_hs) begin
         skid_vld_d = 1'b1;
         skid_d     = in_beat;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign m_tvalid_o = main_vld_q;
   assign m_tdata_o  = main_q[DSIZE-1:0];
   assign m_tlast_o  = main_q[DSIZE];
   assign m_tuser_o  = main_q[W-1 -: USIZE];

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// rtl/axis_pkt_rr_arbiter.sv - packet-locked round-robin arbiter of NUM streams onto one output
module axis_pkt_rr_arbiter
   import axis_arb_pkg::*;
#(
   parameter  int NUM   = 4,
   parameter  int DSIZE = 16,
   parameter  int USIZE = 1,
   localparam int IDW   = $clog2(NUM)
) (
   input  logic                 clock,
   input  logic                 rst_n,
   input  logic [NUM-1:0]       s_tvalid_i,
   output logic [NUM-1:0]       s_tready_o,
   input  logic [NUM*DSIZE-1:0] s_tdata_i,
   input  logic [NUM-1:0]       s_tlast_i,
   input  logic [NUM*USIZE-1:0] s_tuser_i,
   output logic                 m_tvalid_o,
   input  logic                 m_tready_i,
   output logic [DSIZE-1:0]     m_tdata_o,
   output logic                 m_tlast_o,
   output logic [USIZE-1:0]     m_tuser_o,
   output logic                 grant_vld,
   output logic [IDW-1:0]       grant_id,
   output logic                 pkt_done,
   output logic [15:0]          beat_cnt
);

   arb_state_e       state_q, state_d;
   logic [IDW-1:0]   grant_q, grant_d, last_ptr_q, last_ptr_d;
   logic [15:0]      beat_cnt_q, beat_cnt_d;
   logic             sel_valid, sel_last, slice_ready, beat_hs;
   logic [DSIZE-1:0] sel_data;
   logic [USIZE-1:0] sel_user;

   assign sel_valid = (state_q == LOCK) & s_tvalid_i[grant_q];
   assign sel_last  = s_tlast_i[grant_q];
   assign sel_data  = s_tdata_i[int'(grant_q)*DSIZE +: DSIZE];
   assign sel_user  = s_tuser_i[int'(grant_q)*USIZE +: USIZE];
   assign beat_hs   = sel_valid & slice_ready;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_ptr_d = last_ptr_q;
      beat_cnt_d = beat_cnt_q;
      s_tready_o = '0;
      pkt_done   = 1'b0;
      case (state_q)
         IDLE: begin
            if (|s_tvalid_i) begin
               state_d    = LOCK;
               grant_d    = IDW'(rr_pick(16'(s_tvalid_i), 4'(last_ptr_q), 5'(NUM)));
               beat_cnt_d = 16'd0;
            end
         end
         LOCK: begin
            s_tready_o[grant_q] = slice_ready;
            if (beat_hs) begin
               if (beat_cnt_q != 16'hFFFF) beat_cnt_d = beat_cnt_q + 16'd1;
               // Only tlast releases the lock; a gap in tvalid just waits.
               if (sel_last) begin
                  pkt_done   = 1'b1;
                  last_ptr_d = grant_q;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         last_ptr_q <= IDW'(NUM - 1);
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_ptr_q <= last_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   axis_reg_slice #(
      .DSIZE (DSIZE),
      .USIZE (USIZE)
   ) u_slice (
      .clock      (clock),
      .rst_n      (rst_n),
      .s_tvalid_i (sel_valid),
      .s_tready_o (slice_ready),
      .s_tdata_i  (sel_data),
      .s_tlast_i  (sel_last),
      .s_tuser_i  (sel_user),
      .m_tvalid_o (m_tvalid_o),
      .m_tready_i (m_tready_i),
      .m_tdata_o  (m_tdata_o),
      .m_tlast_o  (m_tlast_o),
      .m_tuser_o  (m_tuser_o)
   );

   assign grant_vld = (state_q == LOCK);
   assign grant_id  = grant_q;
   assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// tb/tb_axis_pkt_rr_arbiter.sv - vector table plus directed packet sequences for the arbiter
module tb_axis_pkt_rr_arbiter;

   localparam int NUM   = 4;
   localparam int DSIZE = 16;
   localparam int USIZE = 1;

   typedef logic [DSIZE:0]       beat_t;
   typedef logic [DSIZE+USIZE:0] rec_t;

   typedef struct packed {
      logic        vld;
      logic [15:0] data;
      logic        last;
      logic        mv;
      logic [15:0] md;
      logic        ml;
      logic        gv;
      logic [1:0]  gid;
      logic [3:0]  rdy;
      logic        done;
      logic [15:0] cnt;
   } vec_t;

   logic                 clock = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NUM-1:0]       s_tvalid = '0, s_tready, s_tlast = '0;
   logic [NUM*DSIZE-1:0] s_tdata = '0;
   logic [NUM*USIZE-1:0] s_tuser = '0;
   logic                 m_tvalid, m_tready = 1'b1, m_tlast;
   logic [DSIZE-1:0]     m_tdata;
   logic [USIZE-1:0]     m_tuser;
   logic                 grant_vld, pkt_done;
   logic [1:0]           grant_id;
   logic [15:0]          beat_cnt;

   int checks = 0;
   int errors = 0;

   beat_t          srcq [NUM][$];
   rec_t           outq [$];
   rec_t           expq [$];
   int             grantq [$];
   int             acc [NUM];
   logic [NUM-1:0] lastacc, hold;
   logic           rst_req, rdy_mode, prev_stall, prev_done, prev_gv;
   rec_t           prev_beat;
   logic [3:0]     pat = 4'b1001;
   int             cyc = 0;
   int             npkt = 0;
   vec_t           vt [7];

   always #5 clock = ~clock;

   axis_pkt_rr_arbiter #(.NUM(NUM), .DSIZE(DSIZE), .USIZE(USIZE)) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .s_tvalid_i (s_tvalid),
      .s_tready_o (s_tready),
      .s_tdata_i  (s_tdata),
      .s_tlast_i  (s_tlast),
      .s_tuser_i  (s_tuser),
      .m_tvalid_o (m_tvalid),
      .m_tready_i (m_tready),
      .m_tdata_o  (m_tdata),
      .m_tlast_o  (m_tlast),
      .m_tuser_o  (m_tuser),
      .grant_vld  (grant_vld),
      .grant_id   (grant_id),
      .pkt_done   (pkt_done),
      .beat_cnt   (beat_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] enc(input int p, input int k, input int b);
      return {4'(p), 4'(k), 8'(b)};
   endfunction

   task automatic push_pkt(input int p, input int k, input int n);
      for (int b = 0; b < n; b++) srcq[p].push_back({(b == n - 1), enc(p, k, b)});
   endtask

   task automatic push_exp(input int p, input int k, input int n);
      logic [15:0] d;
      for (int b = 0; b < n; b++) begin
         d = enc(p, k, b);
         expq.push_back({d[0], (b == n - 1), d});
      end
   endtask

   // One clock: drive at negedge, sample 2 ns later, well before the next posedge.
   task automatic cycle();
      logic [NUM-1:0] mask;
      beat_t          b;
      @(negedge clock);
      rst_n = rst_req;
      for (int p = 0; p < NUM; p++) begin
         b = (srcq[p].size() > 0) ? srcq[p][0] : '0;
         s_tvalid[p]                = (srcq[p].size() > 0) && !hold[p];
         s_tlast[p]                 = b[DSIZE];
         s_tdata[p*DSIZE +: DSIZE]  = b[DSIZE-1:0];
         s_tuser[p]                 = b[0];
      end
      m_tready = rdy_mode ? pat[2'(cyc)] : 1'b1;
      #2;
      for (int p = 0; p < NUM; p++) begin
         if (s_tvalid[p] && s_tready[p]) begin
            b = srcq[p].pop_front();
            acc[p]++;
            if (b[DSIZE]) lastacc[p] = 1'b1;
         end
      end
      mask = grant_vld ? (NUM'(1) << grant_id) : '0;
      check("tready_exclusive", 32'(s_tready & ~mask), 32'(0));
      if (prev_stall && rst_n) begin
         check("stall_valid", 32'(m_tvalid), 32'(1));
         check("stall_data", 32'({m_tuser, m_tlast, m_tdata}), 32'(prev_beat));
      end
      if (prev_done) check("idle_after_done", 32'(grant_vld), 32'(0));
      if (m_tvalid && m_tready) outq.push_back({m_tuser, m_tlast, m_tdata});
      if (pkt_done) npkt++;
      if (grant_vld && !prev_gv) grantq.push_back(int'(grant_id));
      prev_stall = m_tvalid & ~m_tready;
      prev_beat  = {m_tuser, m_tlast, m_tdata};
      prev_done  = pkt_done;
      prev_gv    = grant_vld;
      cyc++;
   endtask

   task automatic clear_tracking();
      outq.delete();
      expq.delete();
      grantq.delete();
      npkt       = 0;
      lastacc    = '0;
      prev_stall = 1'b0;
      prev_done  = 1'b0;
      prev_gv    = 1'b0;
      for (int p = 0; p < NUM; p++) acc[p] = 0;
   endtask

   task automatic do_reset();
      rst_req  = 1'b0;
      hold     = '0;
      rdy_mode = 1'b0;
      for (int p = 0; p < NUM; p++) srcq[p].delete();
      cycle();
      cycle();
      rst_req = 1'b1;
      cycle();
      clear_tracking();
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_m_tvalid"}, 32'(m_tvalid), 32'(0));
      check({tag, "_m_tdata"}, 32'(m_tdata), 32'(0));
      check({tag, "_m_tlast"}, 32'(m_tlast), 32'(0));
      check({tag, "_m_tuser"}, 32'(m_tuser), 32'(0));
      check({tag, "_s_tready"}, 32'(s_tready), 32'(0));
      check({tag, "_grant_vld"}, 32'(grant_vld), 32'(0));
      check({tag, "_grant_id"}, 32'(grant_id), 32'(0));
      check({tag, "_pkt_done"}, 32'(pkt_done), 32'(0));
      check({tag, "_beat_cnt"}, 32'(beat_cnt), 32'(0));
   endtask

   task automatic run_until(input int n, input int budget);
      for (int c = 0; c < budget && outq.size() < n; c++) cycle();
   endtask

   task automatic compare_out(input string tag);
      check({tag, "_count"}, 32'(outq.size()), 32'(expq.size()));
      for (int i = 0; i < expq.size() && i < outq.size(); i++)
         check($sformatf("%s_beat%0d", tag, i), 32'(outq[i]), 32'(expq[i]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //          vld data   last  mv   md     ml    gv   gid   rdy      done  cnt
      vt[0] = '{1'b1, 16'h1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 16'd0};
      vt[1] = '{1'b1, 16'h1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 16'd0};
      vt[2] = '{1'b1, 16'h2, 1'b0, 1'b1, 16'h1, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 16'd1};
      vt[3] = '{1'b1, 16'h3, 1'b0, 1'b1, 16'h2, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 16'd2};
      vt[4] = '{1'b1, 16'h4, 1'b1, 1'b1, 16'h3, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 16'd3};
      vt[5] = '{1'b0, 16'h0, 1'b0, 1'b1, 16'h4, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 16'd4};
      vt[6] = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 16'd4};

      rst_req = 1'b0;
      clear_tracking();
      do_reset();
      check_reset("reset");

      // Port 1 four-beat packet, cycle by cycle.
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         s_tvalid = {2'b00, vt[i].vld, 1'b0};
         s_tlast  = {2'b00, vt[i].last, 1'b0};
         s_tdata  = {16'h0, 16'h0, vt[i].data, 16'h0};
         s_tuser  = '0;
         m_tready = 1'b1;
         #2;
         check($sformatf("vec%0d_m_tvalid", i), 32'(m_tvalid), 32'(vt[i].mv));
         if (vt[i].mv) begin
            check($sformatf("vec%0d_m_tdata", i), 32'(m_tdata), 32'(vt[i].md));
            check($sformatf("vec%0d_m_tlast", i), 32'(m_tlast), 32'(vt[i].ml));
            check($sformatf("vec%0d_m_tuser", i), 32'(m_tuser), 32'(0));
         end
         check($sformatf("vec%0d_grant_vld", i), 32'(grant_vld), 32'(vt[i].gv));
         if (vt[i].gv) check($sformatf("vec%0d_grant_id", i), 32'(grant_id), 32'(vt[i].gid));
         check($sformatf("vec%0d_s_tready", i), 32'(s_tready), 32'(vt[i].rdy));
         check($sformatf("vec%0d_pkt_done", i), 32'(pkt_done), 32'(vt[i].done));
         check($sformatf("vec%0d_beat_cnt", i), 32'(beat_cnt), 32'(vt[i].cnt));
      end

      // All ports, two 3-beat packets each, strict rotation.
      do_reset();
      for (int p = 0; p < NUM; p++) begin
         push_pkt(p, 0, 3);
         push_pkt(p, 1, 3);
      end
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < NUM; p++) push_exp(p, k, 3);
      run_until(24, 200);
      compare_out("rot");
      check("rot_pkts", 32'(npkt), 32'(8));

      // Port 2 locked with a tvalid gap while port 0 waits.
      do_reset();
      push_pkt(2, 0, 8);
      push_exp(2, 0, 8);
      push_exp(0, 0, 2);
      for (int c = 0; c < 80 && outq.size() < 10; c++) begin
         hold[2] = (c >= 3 && c <= 5);
         if (c == 1) push_pkt(0, 0, 2);
         cycle();
         if (!lastacc[2]) check("lock_p0_ready", 32'(s_tready[0]), 32'(0));
      end
      hold = '0;
      compare_out("lock");
      check("lock_beat_cnt", 32'(beat_cnt), 32'(2));

      // Backpressure pattern 1,0,0,1 on a 6-beat packet.
      do_reset();
      rdy_mode = 1'b1;
      push_pkt(1, 3, 6);
      push_exp(1, 3, 6);
      run_until(6, 100);
      for (int c = 0; c < 4; c++) cycle();
      compare_out("bp");
      check("bp_pkts", 32'(npkt), 32'(1));
      check("bp_beat_cnt", 32'(beat_cnt), 32'(6));
      rdy_mode = 1'b0;

      // Reset after beat 3 of a 5-beat packet on port 3.
      do_reset();
      push_pkt(3, 0, 5);
      for (int c = 0; c < 40 && acc[3] < 3; c++) cycle();
      check("rst_pre_beats", 32'(acc[3]), 32'(3));
      rst_req = 1'b0;
      cycle();
      cycle();
      check_reset("midrst");
      for (int p = 0; p < NUM; p++) srcq[p].delete();
      rst_req = 1'b1;
      cycle();
      clear_tracking();
      push_pkt(0, 1, 1);
      push_pkt(3, 1, 1);
      push_exp(0, 1, 1);
      push_exp(3, 1, 1);
      run_until(2, 40);
      compare_out("midrst");
      check("midrst_first_grant", (grantq.size() > 0) ? 32'(grantq[0]) : 32'hFF, 32'(0));

      // Ports 0 and 2 alternating single-beat packets.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         push_pkt(0, k, 1);
         push_pkt(2, k, 1);
         push_exp(0, k, 1);
         push_exp(2, k, 1);
      end
      run_until(6, 60);
      cycle();
      compare_out("alt");
      check("alt_pkts", 32'(npkt), 32'(6));
      check("alt_grants", 32'(grantq.size()), 32'(6));
      for (int i = 0; i < 6 && i < grantq.size(); i++)
         check($sformatf("alt_grant%0d", i), 32'(grantq[i]), (i % 2 == 0) ? 32'(0) : 32'(2));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_pkt_rr_arbiter.md
AXIS_PKT_RR_ARBITER -- requirements
Module: axis_pkt_rr_arbiter

Interface
REQ-001 Parameter NUM, default 4, number of requesting stream ports (2..16).
REQ-002 Parameter DSIZE, default 16, tdata width in bits.
REQ-003 Parameter USIZE, default 1, tuser width in bits.
REQ-004 clock  input  1  single clock for all logic.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 s_inf  axi_stream_inf.slave [NUM]  requester streams (tvalid/tready/tdata/tlast/tuser), DSIZE/USIZE matched.
REQ-007 m_inf  axi_stream_inf.master  shared output stream toward the single datapath consumer.
REQ-008 grant_vld  output  1  high while a port holds the packet lock.
REQ-009 grant_id  output  $clog2(NUM)  index of the locked port; valid when grant_vld=1.
REQ-010 pkt_done  output  1  one-cycle pulse when a tlast beat is accepted from the locked port.
REQ-011 beat_cnt  output  16  beats accepted in the current packet; saturates at 16'hFFFF.

Function
REQ-012 FSM states: IDLE, LOCK.
REQ-013 IDLE: with any s_inf[i].tvalid=1, the first requesting port searched from last_ptr+1 upward, wrapping NUM-1 -> 0, is chosen; next cycle is LOCK with grant_id=i.
REQ-014 IDLE with no tvalid stays in IDLE; every s_inf tready=0.
REQ-015 LOCK: the selected port's tready equals the input-side ready of the output register slice; every other port's tready=0.
REQ-016 LOCK: beats pass tdata/tlast/tuser unmodified, in order, one beat per cycle sustained while m_inf.tready=1.
REQ-017 An accepted beat with tlast=1 from the locked port: pkt_done pulses the same cycle it is accepted, last_ptr<=grant_id, FSM returns to IDLE next cycle, grant_vld=0 for at least one cycle.
REQ-018 The lock is never released without tlast; the selected port dropping tvalid mid-packet holds LOCK.
REQ-019 Latency: a first beat presented in IDLE appears on m_inf 2 cycles later (1 arbitration + 1 register slice) when m_inf.tready=1.
REQ-020 m_inf.tready=0 holds the output beat stable; m_inf.tvalid never drops before the handshake completes; no beat is lost or duplicated.
REQ-021 beat_cnt clears to 0 on entry to LOCK and increments per accepted beat, tlast beat included.
REQ-022 Single-beat packets (tlast on first beat) are legal and produce one pkt_done.
REQ-023 Simultaneous requests from all ports are served in strict rotation; no port waits more than NUM-1 packets.

Reset
REQ-024 Reset state: FSM=IDLE, last_ptr=NUM-1 (port 0 first), m_inf.tvalid=0, tdata=0, tlast=0, tuser=0, all s_inf tready=0, grant_vld=0, grant_id=0, pkt_done=0, beat_cnt=0.
REQ-025 Reset asserted mid-packet discards the in-flight packet and register-slice content; after deassertion arbitration restarts from port 0.
REQ-026 No output is driven from uninitialised state in the first cycle after rst_n deasserts.

Structure
REQ-027 Package axis_arb_pkg holds the FSM state enum (IDLE, LOCK) and the rotate-priority-pick function.
REQ-028 One sub-module, axis_reg_slice: two-entry skid buffer, full throughput, registered tvalid and tready, DSIZE/USIZE parameters, same clock/rst_n.
REQ-029 The arbiter is otherwise a single module; total RTL is 120-400 lines.

Verification
REQ-030 Port 1 only, 4-beat packet 0x0001..0x0004, m tready=1 -> grant_id=1, first beat on m_inf at cycle+2, beats in order, one pkt_done, beat_cnt=4.
REQ-031 All 4 ports each send 2 packets of 3 beats at once -> output packet order 0,1,2,3,0,1,2,3 with no interleaved beats.
REQ-032 Port 2 sends 8 beats with tvalid low for cycles 3-5 while port 0 requests -> port 0 gets no tready until port 2's tlast is accepted.
REQ-033 m tready toggles 1,0,0,1 repeating during a 6-beat packet -> all 6 beats delivered exactly once, tdata stable while stalled.
REQ-034 rst_n pulled low for 2 cycles after beat 3 of a 5-beat packet on port 3 -> all outputs at reset values; next request from ports 0 and 3 together is granted to port 0.
REQ-035 Ports 0 and 2 each send consecutive single-beat packets -> grants alternate 0,2,0,2; one idle grant_vld=0 cycle between packets.
